// File: rtl/pipe_pkg.sv
// Shared constants and payload layouts for the generic pipeline stage register.
// The field offsets and control bit indices describe the ID/EX instantiation.
package pipe_pkg;

    localparam int unsigned ID_EX_DATA_W = 138;
    localparam int unsigned ID_EX_CTRL_W = 10;
    localparam int unsigned ALUOP_W      = 3;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned REG_IDX_W    = 5;

    localparam int unsigned CTRL_REGDST    = 0;
    localparam int unsigned CTRL_ALUSRC    = 1;
    localparam int unsigned CTRL_MEMTOREG  = 2;
    localparam int unsigned CTRL_REGWRITE  = 3;
    localparam int unsigned CTRL_MEMREAD   = 4;
    localparam int unsigned CTRL_MEMWRITE  = 5;
    localparam int unsigned CTRL_PCSRC     = 6;
    localparam int unsigned CTRL_ALUOP_LSB = 7;
    localparam int unsigned CTRL_ALUOP_MSB = 9;

    localparam int unsigned RT_LSB      = 0;
    localparam int unsigned RD_LSB      = 5;
    localparam int unsigned IMM_LSB     = 10;
    localparam int unsigned RS_DATA_LSB = 42;
    localparam int unsigned RT_DATA_LSB = 74;
    localparam int unsigned PC_LSB      = 106;

    // Packed views of the ID/EX payload; member order matches the offsets above.
    typedef struct packed {
        logic [WORD_W-1:0]    pc;
        logic [WORD_W-1:0]    rt_data;
        logic [WORD_W-1:0]    rs_data;
        logic [WORD_W-1:0]    imm;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rt;
    } id_ex_data_t;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               pc_src;
        logic               mem_write;
        logic               mem_read;
        logic               reg_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic               reg_dst;
    } id_ex_ctrl_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding register: valid + control + payload with load/clear.
// Clear beats load and zeroes control but leaves the payload untouched.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = ID_EX_DATA_W,
    parameter int unsigned CTRL_W = ID_EX_CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush and
// an optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = ID_EX_DATA_W,
    parameter int unsigned CTRL_W      = ID_EX_CTRL_W,
    parameter bit          SKID        = 1'b1,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic accept;
    logic retire;

    assign accept = in_valid & in_ready;
    assign retire = out_valid & out_ready;

    if (SKID == 1'b0) begin : g_single
        // Single slot: a retiring beat frees the slot in the same cycle.
        assign in_ready = out_ready | ~out_valid;

        pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_main (
            .clk     (clk),
            .rst     (rst),
            .load    (accept),
            .clear   (flush | (retire & ~accept)),
            .in_data (in_data),
            .in_ctrl (in_ctrl),
            .valid   (out_valid),
            .data    (out_data),
            .ctrl    (out_ctrl)
        );
    end else begin : g_skid
        skid_state_t       state;
        logic              ready_q;
        logic              main_load;
        logic              main_clear;
        logic              skid_load;
        logic              skid_clear;
        logic              skid_valid;
        logic [DATA_W-1:0] skid_data;
        logic [CTRL_W-1:0] skid_ctrl;
        logic [DATA_W-1:0] main_in_data;
        logic [CTRL_W-1:0] main_in_ctrl;

        assign in_ready = ready_q;

        // Occupancy FSM; ready_q mirrors "next state is not FULL".
        always_ff @(posedge clk) begin
            if (rst || flush) begin
                state   <= SKID_EMPTY;
                ready_q <= 1'b1;
            end else begin
                case (state)
                    SKID_EMPTY: begin
                        if (accept) begin
                            state <= SKID_ONE;
                        end
                    end
                    SKID_ONE: begin
                        if (accept && !retire) begin
                            state   <= SKID_FULL;
                            ready_q <= 1'b0;
                        end else if (retire && !accept) begin
                            state <= SKID_EMPTY;
                        end
                    end
                    SKID_FULL: begin
                        if (retire) begin
                            state   <= SKID_ONE;
                            ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state   <= SKID_EMPTY;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end

        always_comb begin
            main_load  = 1'b0;
            main_clear = 1'b0;
            skid_load  = 1'b0;
            skid_clear = 1'b0;
            case (state)
                SKID_EMPTY: main_load = accept;
                SKID_ONE: begin
                    main_load  = accept & retire;
                    skid_load  = accept & ~retire;
                    main_clear = retire & ~accept;
                end
                SKID_FULL: begin
                    main_load  = retire;
                    skid_clear = retire;
                end
                default: main_clear = 1'b1;
            endcase
        end

        // The skid entry is only occupied in FULL, so it is the refill source then.
        assign main_in_data = skid_valid ? skid_data : in_data;
        assign main_in_ctrl = skid_valid ? skid_ctrl : in_ctrl;

        pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_main (
            .clk     (clk),
            .rst     (rst),
            .load    (main_load),
            .clear   (main_clear | flush),
            .in_data (main_in_data),
            .in_ctrl (main_in_ctrl),
            .valid   (out_valid),
            .data    (out_data),
            .ctrl    (out_ctrl)
        );

        pipe_slot #(
            .DATA_W (DATA_W),
            .CTRL_W (CTRL_W)
        ) u_skid (
            .clk     (clk),
            .rst     (rst),
            .load    (skid_load),
            .clear   (skid_clear | flush),
            .in_data (in_data),
            .in_ctrl (in_ctrl),
            .valid   (skid_valid),
            .data    (skid_data),
            .ctrl    (skid_ctrl)
        );
    end

    // Saturating count of cycles the downstream stage holds us off.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed handshake/flush/saturation steps plus
// randomized traffic checked against a queue model of the stage occupancy.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 138;
    localparam int unsigned CW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          f0, iv0, ir0, ov0, or0;
    logic [DW-1:0] id0, od0;
    logic [CW-1:0] ic0, oc0;
    logic [15:0]   sc0;

    logic          f1, iv1, ir1, ov1, or1;
    logic [DW-1:0] id1, od1;
    logic [CW-1:0] ic1, oc1;
    logic [15:0]   sc1;

    logic          f4, iv4, ir4, ov4, or4;
    logic [DW-1:0] id4, od4;
    logic [CW-1:0] ic4, oc4;
    logic [3:0]    sc4;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .STALL_CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .flush(f0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .in_ctrl(ic0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_ctrl(oc0),
        .stall_cnt(sc0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .STALL_CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .flush(f1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .in_ctrl(ic1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_ctrl(oc1),
        .stall_cnt(sc1)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(f4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .in_ctrl(ic4), .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_ctrl(oc4),
        .stall_cnt(sc4)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } beat_t;

    beat_t q[$];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Model: the stage is a FIFO of depth 1 (SKID=0) or 2 (SKID=1); its head is the output.
    task automatic rand_phase(input bit skid, input int n);
        beat_t       pend;
        bit          have;
        int unsigned sc;
        logic        iv, ordy, fl, ir_exp;
        logic        ov, irr;
        logic [DW-1:0] od;
        logic [CW-1:0] oc;
        logic [15:0] st;
        have = 1'b0;
        sc   = 0;
        pend = '0;
        q.delete();
        for (int i = 0; i < n; i++) begin
            ov = skid ? ov1 : ov0;
            od = skid ? od1 : od0;
            oc = skid ? oc1 : oc0;
            st = skid ? sc1 : sc0;
            chk("rnd_out_valid", DW'(ov), DW'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_out_data", od, q[0].d);
                chk("rnd_out_ctrl", DW'(oc), DW'(q[0].c));
            end else begin
                chk("rnd_bubble_ctrl", DW'(oc), '0);
            end
            chk("rnd_stall_cnt", DW'(st), DW'(sc));

            if (!have) begin
                pend.d = DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
                pend.c = CW'($urandom());
            end
            iv   = have | ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 49) == 0);
            if (skid) begin
                iv1 = iv; id1 = pend.d; ic1 = pend.c; or1 = ordy; f1 = fl;
            end else begin
                iv0 = iv; id0 = pend.d; ic0 = pend.c; or0 = ordy; f0 = fl;
            end
            #1;
            ir_exp = skid ? (q.size() < 2) : (ordy | (q.size() == 0));
            irr    = skid ? ir1 : ir0;
            chk("rnd_in_ready", DW'(irr), DW'(ir_exp));

            if (q.size() != 0 && !ordy && sc < 32'hFFFF) sc++;
            if (q.size() != 0 && ordy) void'(q.pop_front());
            if (iv && ir_exp) q.push_back(pend);
            if (fl) q.delete();
            have = iv & ~ir_exp;
            @(posedge clk);
            #1;
        end
        iv0 = 1'b0; or0 = 1'b0; f0 = 1'b0;
        iv1 = 1'b0; or1 = 1'b0; f1 = 1'b0;
    endtask

    initial begin
        f0 = 1'b0; iv0 = 1'b0; id0 = '0; ic0 = '0; or0 = 1'b0;
        f1 = 1'b0; iv1 = 1'b1; id1 = DW'(32'h55); ic1 = CW'(10'h3FF); or1 = 1'b0;
        f4 = 1'b0; iv4 = 1'b0; id4 = '0; ic4 = '0; or4 = 1'b0;

        // Reset held two cycles with a beat offered
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", DW'(ov1), '0);
        chk("rst_out_ctrl", DW'(oc1), '0);
        chk("rst_out_data", od1, '0);
        chk("rst_stall_cnt", DW'(sc1), '0);
        rst = 1'b0;
        iv1 = 1'b0;
        chk("rst_in_ready", DW'(ir1), DW'(1'b1));
        tick();
        chk("post_rst_in_ready", DW'(ir1), DW'(1'b1));
        chk("post_rst_out_valid", DW'(ov1), '0);

        // Back-to-back stream with out_ready high
        or1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            iv1 = 1'b1;
            id1 = DW'(i);
            ic1 = CW'(i);
            if (i == 1) chk("stream_first_empty", DW'(ov1), '0);
            else begin
                chk("stream_out_valid", DW'(ov1), DW'(1'b1));
                chk("stream_out_data", od1, DW'(i - 1));
            end
            chk("stream_in_ready", DW'(ir1), DW'(1'b1));
            tick();
        end
        iv1 = 1'b0;
        chk("stream_last_data", od1, DW'(8));
        chk("stream_last_ctrl", DW'(oc1), DW'(8));
        tick();
        chk("stream_drained", DW'(ov1), '0);
        chk("stream_drained_ctrl", DW'(oc1), '0);

        // Back-pressure fills the skid, then drains in order
        iv1 = 1'b1; id1 = DW'(32'hA); ic1 = CW'(1); or1 = 1'b1;
        tick();
        id1 = DW'(32'hB); ic1 = CW'(2); or1 = 1'b0;
        chk("bp_accept_b_ready", DW'(ir1), DW'(1'b1));
        tick();
        id1 = DW'(32'hC); ic1 = CW'(3);
        chk("bp_full_ready", DW'(ir1), '0);
        chk("bp_hold_a1", od1, DW'(32'hA));
        tick();
        chk("bp_full_ready2", DW'(ir1), '0);
        chk("bp_hold_a2", od1, DW'(32'hA));
        tick();
        chk("bp_stall_cnt", DW'(sc1), DW'(3));
        chk("bp_out_a", od1, DW'(32'hA));
        or1 = 1'b1;
        tick();
        chk("bp_out_b", od1, DW'(32'hB));
        chk("bp_ready_after", DW'(ir1), DW'(1'b1));
        tick();
        iv1 = 1'b0;
        chk("bp_out_c", od1, DW'(32'hC));
        chk("bp_out_c_ctrl", DW'(oc1), DW'(3));
        tick();
        chk("bp_drained", DW'(ov1), '0);
        chk("bp_stall_kept", DW'(sc1), DW'(3));

        // Flush while FULL with a beat offered
        iv1 = 1'b1; id1 = DW'(32'h11); ic1 = CW'(4); or1 = 1'b0;
        tick();
        id1 = DW'(32'h12); ic1 = CW'(5);
        tick();
        chk("fl_full_ready", DW'(ir1), '0);
        f1 = 1'b1; id1 = DW'(32'hD); ic1 = CW'(6);
        tick();
        f1 = 1'b0; iv1 = 1'b0;
        chk("fl_out_valid", DW'(ov1), '0);
        chk("fl_out_ctrl", DW'(oc1), '0);
        chk("fl_in_ready", DW'(ir1), DW'(1'b1));
        chk("fl_data_held", od1, DW'(32'h11));
        chk("fl_stall_not_cleared", DW'(sc1), DW'(5));
        or1 = 1'b1;
        tick();
        chk("fl_no_d", DW'(ov1), '0);

        // Flush together with retire and accept leaves the stage empty
        iv1 = 1'b1; id1 = DW'(32'h21); ic1 = CW'(7);
        tick();
        chk("flr_loaded", od1, DW'(32'h21));
        f1 = 1'b1; id1 = DW'(32'h22); ic1 = CW'(8);
        tick();
        f1 = 1'b0; iv1 = 1'b0;
        chk("flr_empty", DW'(ov1), '0);
        chk("flr_ctrl", DW'(oc1), '0);
        tick();
        chk("flr_still_empty", DW'(ov1), '0);

        // Narrow stall counter saturates
        iv4 = 1'b1; id4 = DW'(32'h5); ic4 = CW'(9); or4 = 1'b0;
        tick();
        iv4 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("sat_stall_cnt", DW'(sc4), DW'((k < 15) ? k : 15));
            tick();
        end
        chk("sat_final", DW'(sc4), DW'(15));
        chk("sat_data_stable", od4, DW'(32'h5));
        chk("sat_valid", DW'(ov4), DW'(1'b1));

        // Randomized traffic against the queue model
        do_reset();
        rand_phase(1'b0, 10000);
        do_reset();
        rand_phase(1'b1, 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
